// File: rtl/sram_reader.sv
// Burst reader for an asynchronous SRAM: holds OE/ADDR for WAIT_CYCLES, captures Data,
// then presents each word on a valid/ready output. It never drives the SRAM data bus.
//
// state  | meaning
// IDLE   | waiting for start; OE high, ADDR holds last value
// READ   | OE low, ADDR stable, wait timer counting down
// HOLD   | word captured, waiting for rd_ready
// FINISH | one-cycle done pulse, then back to IDLE
module sram_reader #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [19:0] base_addr,
  input  logic [19:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        OE,
  output logic        WE,
  output logic        CE,
  output logic        LB,
  output logic        UB
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FINISH} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] addr_q;
  logic [19:0] remain_q;
  logic [3:0]  wait_cnt_q;
  logic        xfer;
  logic        wait_tc;
  logic        enter_read;

  assign Data = 16'hzzzz;
  assign WE   = 1'b1;
  assign CE   = 1'b0;
  assign LB   = 1'b0;
  assign UB   = 1'b0;

  assign xfer       = (state_q == HOLD) && rd_valid && rd_ready;
  assign wait_tc    = (wait_cnt_q == 4'd0);
  assign enter_read = (state_d == READ) && (state_q != READ);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    OE      = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) state_d = (word_count == 20'd0) ? FINISH : READ;
      end
      READ: begin
        busy = 1'b1;
        OE   = 1'b0;
        if (abort)        state_d = IDLE;
        else if (wait_tc) state_d = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (abort)     state_d = IDLE;
        else if (xfer) state_d = (remain_q == 20'd1) ? FINISH : READ;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 20'd0;
      remain_q   <= 20'd0;
      wait_cnt_q <= 4'd0;
      ADDR       <= 20'd0;
      rd_data    <= 16'd0;
      rd_valid   <= 1'b0;
    end else begin
      if (state_q == IDLE && start && word_count != 20'd0) begin
        addr_q   <= base_addr;
        remain_q <= word_count;
      end

      // ADDR only moves when a new READ begins, so it holds the last read address otherwise
      if (enter_read) begin
        wait_cnt_q <= WAIT_LOAD;
        ADDR       <= (state_q == IDLE) ? base_addr : addr_q + 20'd1;
      end else if (state_q == READ && !wait_tc) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end

      if (state_q == READ && !abort && wait_tc) begin
        rd_data  <= Data;
        rd_valid <= 1'b1;
      end

      // A transfer coinciding with abort still consumes the word
      if (xfer) begin
        addr_q   <= addr_q + 20'd1;
        remain_q <= remain_q - 20'd1;
      end

      if (xfer || ((state_q == READ || state_q == HOLD) && abort)) rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_reader.sv
// Directed bench for sram_reader with an SRAM model returning ~addr; WAIT_CYCLES=2.
module tb_sram_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, rd_ready;
  logic [19:0] base_addr, word_count;
  logic        busy, done, rd_valid;
  logic [15:0] rd_data;
  logic [19:0] addr;
  wire  [15:0] data;
  logic        oe, we, ce, lb, ub;

  int vectors    = 0;
  int miscompares = 0;

  sram_reader #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .ADDR(addr), .Data(data),
    .OE(oe), .WE(we), .CE(ce), .LB(lb), .UB(ub)
  );

  assign data = ~addr[15:0];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " rd_data"}, rd_data, 0);
    chk({tag, " addr"}, addr, 0);
    chk({tag, " oe"}, oe, 1);
    chk({tag, " we"}, we, 1);
    chk({tag, " ce"}, ce, 0);
    chk({tag, " lb"}, lb, 0);
    chk({tag, " ub"}, ub, 0);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; rd_ready = 1;
    base_addr = 0; word_count = 0;
    step(); step();
    chk_reset_vals("reset");
    reset = 0;
    step();

    // three-word burst at 0x10
    start = 1; base_addr = 20'h00010; word_count = 20'd3;
    step();
    chk("b1 busy", busy, 1);
    chk("b1 oe", oe, 0);
    chk("b1 addr0", addr, 20'h00010);
    chk("b1 valid early", rd_valid, 0);
    start = 0; base_addr = 20'h00555; word_count = 20'd9;
    step();
    chk("b1 valid latency", rd_valid, 0);
    step();
    chk("b1 valid0", rd_valid, 1);
    chk("b1 data0", rd_data, 16'hFFEF);
    chk("b1 hold oe", oe, 1);
    start = 1;
    step();
    chk("b1 addr1", addr, 20'h00011);
    chk("b1 valid clr", rd_valid, 0);
    step(); step();
    start = 0;
    chk("b1 valid1", rd_valid, 1);
    chk("b1 data1", rd_data, 16'hFFEE);
    step(); step(); step();
    chk("b1 data2", rd_data, 16'hFFED);
    chk("b1 done early", done, 0);
    step();
    chk("b1 done", done, 1);
    chk("b1 finish busy", busy, 0);
    chk("b1 finish addr", addr, 20'h00012);
    step();
    chk("b1 done once", done, 0);

    // zero-length burst
    start = 1; word_count = 20'd0; base_addr = 20'h00777;
    step();
    start = 0;
    chk("z done", done, 1);
    chk("z oe", oe, 1);
    chk("z valid", rd_valid, 0);
    chk("z addr", addr, 20'h00012);
    step();
    chk("z done once", done, 0);

    // back-pressure in HOLD
    start = 1; base_addr = 20'h00100; word_count = 20'd2; rd_ready = 0;
    step();
    start = 0;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      chk("bp valid", rd_valid, 1);
      chk("bp data", rd_data, 16'hFEFF);
      chk("bp oe", oe, 1);
      chk("bp addr", addr, 20'h00100);
      step();
    end
    rd_ready = 1;
    chk("bp addr after wait", addr, 20'h00100);
    step();
    chk("bp addr next", addr, 20'h00101);
    step(); step();
    chk("bp data1", rd_data, 16'hFEFE);
    step();
    chk("bp done", done, 1);
    step();

    // address wrap
    start = 1; base_addr = 20'hFFFFF; word_count = 20'd2;
    step();
    start = 0;
    chk("wrap addr0", addr, 20'hFFFFF);
    step(); step();
    chk("wrap data0", rd_data, 16'h0000);
    step();
    chk("wrap addr1", addr, 20'h00000);
    step(); step();
    chk("wrap data1", rd_data, 16'hFFFF);
    step();
    chk("wrap done", done, 1);
    step();

    // abort during second READ of a four-word burst
    start = 1; base_addr = 20'h00200; word_count = 20'd4;
    step();
    start = 0;
    step(); step(); step();
    chk("ab addr1", addr, 20'h00201);
    chk("ab oe read", oe, 0);
    abort = 1;
    step();
    abort = 0;
    chk("ab busy", busy, 0);
    chk("ab valid", rd_valid, 0);
    chk("ab oe", oe, 1);
    chk("ab done", done, 0);
    step();
    chk("ab no done", done, 0);
    chk("ab idle busy", busy, 0);
    start = 1; base_addr = 20'h00300; word_count = 20'd1;
    step();
    start = 0;
    chk("ab restart busy", busy, 1);
    chk("ab restart addr", addr, 20'h00300);
    step(); step();
    chk("ab restart data", rd_data, 16'hFCFF);
    step();
    chk("ab restart done", done, 1);
    step();

    // abort coinciding with a transfer
    start = 1; base_addr = 20'h00500; word_count = 20'd3;
    step();
    start = 0;
    step(); step();
    chk("abx valid", rd_valid, 1);
    abort = 1;
    step();
    abort = 0;
    chk("abx busy", busy, 0);
    chk("abx valid clr", rd_valid, 0);
    chk("abx done", done, 0);
    chk("abx oe", oe, 1);
    step();
    chk("abx stays idle", busy, 0);
    chk("abx no done", done, 0);

    // reset while holding a word
    start = 1; base_addr = 20'h00400; word_count = 20'd3; rd_ready = 0;
    step();
    start = 0;
    chk("rh we read", we, 1);
    step(); step();
    chk("rh valid", rd_valid, 1);
    chk("rh we hold", we, 1);
    reset = 1;
    step();
    chk_reset_vals("rh");
    reset = 0; rd_ready = 1;
    step();
    chk("rh after busy", busy, 0);
    chk("rh after valid", rd_valid, 0);
    chk("rh after we", we, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
